wait_state_memory: RTL and testbench

- Clocked, parametrised successor to the combinational fixed memory model.
- Single-port RAM behind a four-phase read/write/ready handshake, with a programmable number of wait states and error signalling.
- Instanced as the data/instruction store of the risc1 core and benches; stands in for slow external memory by stretching access latency.

---
 rtl/wait_state_memory_if.sv | 29 ++
 rtl/wait_state_memory.sv | 107 ++++++++++
 tb/tb_wait_state_memory.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wait_state_memory_if.sv
// Handshake bus between a requester and wait_state_memory.
//   read, write : request strobes, held until ready is seen
//   address     : word address, captured at request acceptance
//   wdata       : write data, captured at request acceptance
//   rdata       : read data, valid while ready=1 after a read
//   ready       : access complete, held until read and write are both low
//   error       : qualifies ready, 1 = access rejected
interface wait_state_memory_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 7
);
   logic                  read;
   logic                  write;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH-1:0] rdata;
   logic                  ready;
   logic                  error;

   modport master (
      output read, write, address, wdata,
      input  rdata, ready, error
   );

   modport slave (
      input  read, write, address, wdata,
      output rdata, ready, error
   );
endinterface

// File: rtl/wait_state_memory.sv
// Single-port RAM behind a four-phase read/write/ready handshake with a
// programmable number of wait states and error signalling.
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high; memory contents are not cleared
//   bus   : slave side of wait_state_memory_if (read, write, address,
//           wdata in; rdata, ready, error out)
module wait_state_memory #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 7,
   parameter int unsigned DEPTH      = 128,
   parameter int unsigned LATENCY    = 2
) (
   input logic               clk,
   input logic               reset,
   wait_state_memory_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] LATENCY_CNT = 4'(LATENCY);

   logic [1:0]            state;
   logic [3:0]            count;
   logic [ADDR_WIDTH-1:0] addr_cap;
   logic [DATA_WIDTH-1:0] wdata_cap;
   logic                  read_cap;
   logic                  write_cap;
   logic [DATA_WIDTH-1:0] rdata_reg;
   logic                  ready_reg;
   logic                  error_reg;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic req;
   logic in_range;
   logic finish;
   logic commit;

   assign req      = bus.read | bus.write;
   assign in_range = 32'(addr_cap) < DEPTH;
   // WAIT always lasts at least one edge, so ready trails acceptance by
   // LATENCY+1 edges even when LATENCY is zero.
   assign finish   = (state == WAIT) && req && (count == 4'd0);
   // Gated by reset so an access abandoned by reset never commits.
   assign commit   = finish && write_cap && !read_cap && in_range && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= 4'd0;
         ready_reg <= 1'b0;
         error_reg <= 1'b0;
         rdata_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  state     <= WAIT;
                  count     <= LATENCY_CNT;
                  addr_cap  <= bus.address;
                  wdata_cap <= bus.wdata;
                  read_cap  <= bus.read;
                  write_cap <= bus.write;
               end
            end
            WAIT: begin
               if (!req) begin
                  state <= IDLE;
               end else if (count == 4'd0) begin
                  state     <= DONE;
                  ready_reg <= 1'b1;
                  if (!in_range) begin
                     error_reg <= 1'b1;
                     rdata_reg <= '0;
                  end else if (read_cap && write_cap) begin
                     error_reg <= 1'b1;
                  end else begin
                     error_reg <= 1'b0;
                     if (read_cap) rdata_reg <= mem[addr_cap];
                  end
               end else begin
                  count <= count - 4'd1;
               end
            end
            DONE: begin
               if (!req) begin
                  state     <= IDLE;
                  ready_reg <= 1'b0;
                  error_reg <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (commit) mem[addr_cap] <= wdata_cap;
   end

   assign bus.rdata = rdata_reg;
   assign bus.ready = ready_reg;
   assign bus.error = error_reg;

endmodule

// File: tb/tb_wait_state_memory.sv
// Directed bench for wait_state_memory. Three instances:
//   0: LATENCY=2, DEPTH=128   1: LATENCY=2, DEPTH=100   2: LATENCY=0, DEPTH=128
module tb_wait_state_memory;

   logic clk = 1'b0;
   logic reset;

   logic       rd   [3];
   logic       wr   [3];
   logic [6:0] addr [3];
   logic [7:0] wdat [3];
   logic [7:0] rdat [3];
   logic       rdy  [3];
   logic       err  [3];

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned LAT = (g == 2) ? 0 : 2;
      localparam int unsigned DEP = (g == 1) ? 100 : 128;

      wait_state_memory_if #(.DATA_WIDTH(8), .ADDR_WIDTH(7)) bus ();

      assign bus.read    = rd[g];
      assign bus.write   = wr[g];
      assign bus.address = addr[g];
      assign bus.wdata   = wdat[g];
      assign rdat[g]     = bus.rdata;
      assign rdy[g]      = bus.ready;
      assign err[g]      = bus.error;

      wait_state_memory #(
         .DATA_WIDTH(8),
         .ADDR_WIDTH(7),
         .DEPTH     (DEP),
         .LATENCY   (LAT)
      ) dut (
         .clk  (clk),
         .reset(reset),
         .bus  (bus)
      );
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Full handshake: raise request, count edges to ready (acceptance edge is
   // edge 1), check result, hold one edge, drop and check release.
   task automatic access(input int d, input bit r, input bit w, input logic [6:0] a,
                         input logic [7:0] wd, input int exp_edges, input bit exp_err,
                         input logic [7:0] exp_rd, input string tag);
      int n;
      rd[d]   = r;
      wr[d]   = w;
      addr[d] = a;
      wdat[d] = wd;
      n = 0;
      do begin
         step();
         n++;
      end while (!rdy[d] && n < 20);
      check_eq({tag, " edges"}, n, exp_edges);
      check_eq({tag, " ready"}, rdy[d], 1);
      check_eq({tag, " error"}, err[d], exp_err);
      check_eq({tag, " rdata"}, rdat[d], exp_rd);
      addr[d] = 7'd3;
      wdat[d] = 8'h5c;
      step();
      check_eq({tag, " ready held"}, rdy[d], 1);
      check_eq({tag, " error held"}, err[d], exp_err);
      rd[d] = 1'b0;
      wr[d] = 1'b0;
      step();
      check_eq({tag, " ready drop"}, rdy[d], 0);
      check_eq({tag, " error drop"}, err[d], 0);
      check_eq({tag, " rdata hold"}, rdat[d], exp_rd);
   endtask

   initial begin
      bit seen;
      for (int i = 0; i < 3; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdat[i] = '0;
      end
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("reset ready %0d", i), rdy[i], 0);
         check_eq($sformatf("reset error %0d", i), err[i], 0);
         check_eq($sformatf("reset rdata %0d", i), rdat[i], 0);
      end
      step();

      // DEPTH=100: out-of-range accesses rejected, in-range data intact.
      access(1, 0, 1, 7'd20,  8'd66, 4, 0, 8'd0,  "d1 wr 20");
      access(1, 1, 0, 7'd20,  8'd0,  4, 0, 8'd66, "d1 rd 20");
      access(1, 0, 1, 7'd120, 8'd55, 4, 1, 8'd0,  "d1 wr 120");
      access(1, 1, 0, 7'd120, 8'd0,  4, 1, 8'd0,  "d1 rd 120");
      access(1, 1, 0, 7'd20,  8'd0,  4, 0, 8'd66, "d1 rd 20 again");

      // LATENCY=0: ready one edge after acceptance, back to back.
      access(2, 0, 1, 7'd0, 8'haa, 2, 0, 8'h00, "d2 wr 0");
      access(2, 1, 0, 7'd0, 8'h00, 2, 0, 8'haa, "d2 rd 0");

      // LATENCY=2 basic write/read.
      access(0, 0, 1, 7'd102, 8'd123, 4, 0, 8'd0,   "d0 wr 102");
      access(0, 1, 0, 7'd102, 8'd0,   4, 0, 8'd123, "d0 rd 102");

      // read+write together is rejected and leaves memory alone.
      access(0, 0, 1, 7'd5, 8'd77,  4, 0, 8'd123, "d0 wr 5");
      access(0, 1, 1, 7'd5, 8'd200, 4, 1, 8'd123, "d0 rw 5");
      access(0, 1, 0, 7'd5, 8'd0,   4, 0, 8'd77,  "d0 rd 5");

      // Abort in WAIT: ready never rises, no commit.
      access(0, 0, 1, 7'd7, 8'd11, 4, 0, 8'd77, "d0 wr 7");
      wr[0] = 1'b1; addr[0] = 7'd7; wdat[0] = 8'd9;
      step();
      step();
      wr[0] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         seen |= rdy[0];
      end
      check_eq("abort ready seen", seen, 0);
      access(0, 1, 0, 7'd7, 8'd0, 4, 0, 8'd11, "d0 rd 7 after abort");

      // Reset during WAIT: access dropped, rdata cleared, no commit.
      wr[0] = 1'b1; addr[0] = 7'd7; wdat[0] = 8'd33;
      step();
      step();
      reset = 1'b1;
      wr[0] = 1'b0;
      step();
      check_eq("mid reset ready", rdy[0], 0);
      check_eq("mid reset rdata", rdat[0], 0);
      reset = 1'b0;
      step();
      access(0, 1, 0, 7'd7, 8'd0, 4, 0, 8'd11, "d0 rd 7 after reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
      $finish;
   end

endmodule
